// File: rtl/yid_pkg.sv
// rtl/yid_pkg.sv - shared opcodes, immediate formats and field extractors for the ID stage
package yid_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} imm_fmt_e;

  // 32-bit sign-extended immediates; callers widen to XLEN
  function automatic logic [31:0] imm_i(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[31:25], ins[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] ins);
    return {ins[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic imm_fmt_e fmt_of(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_B;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_J;
      default:                  return FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/yid_immgen.sv
// rtl/yid_immgen.sv - combinational immediate generator selected by opcode
module yid_immgen
  import yid_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ins,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt
);

  logic [31:0] raw;

  always_comb begin
    fmt = fmt_of(ins[6:0]);
    raw = 32'd0;
    case (fmt)
      FMT_I:   raw = imm_i(ins);
      FMT_S:   raw = imm_s(ins);
      FMT_B:   raw = imm_b(ins);
      FMT_U:   raw = imm_u(ins);
      FMT_J:   raw = imm_j(ins);
      default: raw = 32'd0;
    endcase
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/yid_stage.sv
// rtl/yid_stage.sv - pipelined RV32I decode stage with register file, hazard detect and ID/EX register
module yid_stage
  import yid_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1,
  localparam int RW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  input  logic            wb_we,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [RW-1:0]   ex_rd,
  input  logic            flush,
  output logic            stall_out,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rd1,
  output logic [XLEN-1:0] out_rd2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_branch,
  output logic [XLEN-1:0] out_jtarget,
  output logic [RW-1:0]   out_rs1,
  output logic [RW-1:0]   out_rs2,
  output logic [RW-1:0]   out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7
);

  logic [XLEN-1:0] rf [NREG];

  logic [RW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rd1, rd2, imm, b_off, j_off;
  imm_fmt_e        fmt;
  logic            rs2_used;

  assign rs1 = in_ins[15 +: RW];
  assign rs2 = in_ins[20 +: RW];
  assign rd  = in_ins[7 +: RW];

  yid_immgen #(.XLEN(XLEN)) u_immgen (
    .ins (in_ins),
    .imm (imm),
    .fmt (fmt)
  );

  // Targets use their own offsets so both exist for every opcode
  assign b_off = XLEN'($signed(imm_b(in_ins)));
  assign j_off = XLEN'($signed(imm_j(in_ins)));

  function automatic logic [XLEN-1:0] rf_read(input logic [RW-1:0] idx);
    if (idx == '0)
      return '0;
    else if (BYPASS != 0 && wb_we && wb_rd == idx)
      return wb_data;
    else
      return rf[idx];
  endfunction

  always_comb begin
    rd1 = rf_read(rs1);
    rd2 = rf_read(rs2);
  end

  assign rs2_used  = (fmt == FMT_S) || (fmt == FMT_B) || (in_ins[6:0] == OP_REG);
  assign stall_out = in_valid && ex_mem_read && (ex_rd != '0) &&
                     ((ex_rd == rs1) || (rs2_used && ex_rd == rs2));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_rd1     <= '0;
      out_rd2     <= '0;
      out_imm     <= '0;
      out_branch  <= '0;
      out_jtarget <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
    end else if (flush || stall_out) begin
      out_valid <= 1'b0;
    end else begin
      out_valid   <= in_valid;
      out_pc      <= in_pc;
      out_rd1     <= rd1;
      out_rd2     <= rd2;
      out_imm     <= imm;
      out_branch  <= in_pc + b_off;
      out_jtarget <= in_pc + j_off;
      out_rs1     <= rs1;
      out_rs2     <= rs2;
      out_rd      <= rd;
      out_opcode  <= in_ins[6:0];
      out_funct3  <= in_ins[14:12];
      out_funct7  <= in_ins[31:25];
    end
  end

endmodule

// File: doc/yid_stage.md
Name: yid_stage

Overview:
- Parametrised, pipelined successor to the combinational instruction decoder.
- Takes a fetched RV32I instruction and its PC, reads the register file, and generates the immediate for all five formats (I/S/B/U/J) plus the branch and jump targets.
- Detects load-use hazards and registers every result into an ID/EX pipeline register with valid/flush/stall control.
- Sits between the fetch stage and the execute stage.

Parameters:
- XLEN, 32, datapath width for registers, PC, immediates and targets.
- NREG, 32, number of architectural registers; register index width is RW = clog2(NREG).
- BYPASS, 1, when 1, a write-back to the register being read this cycle is forwarded to the read; when 0, the read returns the stored value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_ins and in_pc hold a valid instruction.
- in_ins  in  32  instruction word.
- in_pc  in  XLEN  PC of in_ins.
- wb_we  in  1  register write enable from write-back.
- wb_rd  in  RW  write-back destination register.
- wb_data  in  XLEN  write-back data.
- ex_mem_read  in  1  the instruction now in EX is a load.
- ex_rd  in  RW  destination register of the instruction in EX.
- flush  in  1  squash the instruction in ID (taken branch or jump).
- stall_out  out  1  combinational; fetch must hold in_ins and in_pc.
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_pc  out  XLEN  registered PC.
- out_rd1, out_rd2  out  XLEN  registered operands.
- out_imm  out  XLEN  registered, sign-extended immediate.
- out_branch  out  XLEN  registered out_pc + B-immediate.
- out_jtarget  out  XLEN  registered out_pc + J-immediate.
- out_rs1, out_rs2, out_rd  out  RW  registered register indices.
- out_opcode  out  7  registered opcode, ins[6:0].
- out_funct3  out  3  registered funct3, ins[14:12].
- out_funct7  out  7  registered funct7, ins[31:25].

Behaviour:
- Reset: every output register and every register-file entry is 0, and out_valid = 0. Reset asserted mid-operation discards the instruction in flight on that edge.
- Latency: exactly 1 cycle from in_ins to the out_* registers.
- Register file:
  - Two asynchronous read ports and one synchronous write port.
  - x0 always reads 0; a write with wb_rd = 0 is ignored.
  - The write occurs on the edge when wb_we = 1.
  - With BYPASS = 1, if wb_we = 1, wb_rd = rs and rs ≠ 0, the read returns wb_data in the same cycle.
- Immediate selection by opcode (ins[6:0]); all immediates are sign-extended from ins[31]:
  - I-type (0000011, 0010011, 1100111): ins[31:20].
  - S-type (0100011): {ins[31:25], ins[11:7]}.
  - B-type (1100011): {ins[31], ins[7], ins[30:25], ins[11:8], 0}.
  - U-type (0110111, 0010111): {ins[31:12], 12'b0}.
  - J-type (1101111): {ins[31], ins[19:12], ins[20], ins[30:21], 0}.
  - Any other opcode: 0.
- Targets: out_branch and out_jtarget are computed as PC plus the byte-offset immediate, modulo 2^XLEN (wrap-around, no overflow flag). Both are computed for every instruction regardless of type.
- rs2 is "used" only for opcodes 0110011, 0100011 and 1100011.
- Hazard: stall_out = in_valid & ex_mem_read & (ex_rd ≠ 0) & ((ex_rd == rs1) | (rs2 used & ex_rd == rs2)).
- Next-state priority per edge:
  - rst: all outputs and register-file entries cleared.
  - flush: out_valid ← 0 (flush takes priority over stall).
  - stall_out: bubble inserted; out_valid ← 0, other out_* hold their previous values.
  - Otherwise: load all out_*; out_valid ← in_valid.
- Simultaneous write-back and decode of the same register: forwarded when BYPASS = 1; stale value when BYPASS = 0.

Decomposition:
- Shared package yid_pkg holds:
  - opcode constants: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG;
  - enum imm_fmt_e {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE}.
- One sub-module, yid_immgen: purely combinational; takes ins, produces imm and fmt. Reused by the verification model.

Test Plan:
- Reset, then decode addi x5, x0, -1 (0xFFF00293) at PC 0x100 → after 1 cycle: out_imm = 0xFFFFFFFF, out_rd = 5, out_valid = 1.
- Write-back x3 = 0xDEADBEEF while decoding add x1, x3, x0 with BYPASS = 1 → out_rd1 = 0xDEADBEEF. Same stimulus with BYPASS = 0 → out_rd1 = 0; x3 reads 0xDEADBEEF on the next decode.
- beq at PC 0x0 with offset -4 (0xFE000EE3) → out_branch = 0xFFFFFFFC (wrap-around). jal x0 +2048 at PC 0x1000 → out_jtarget = 0x1800.
- ex_mem_read = 1, ex_rd = 2, decode add x1, x2, x3 → stall_out = 1, next out_valid = 0. Same setup decoding lui x2 → stall_out = 0.
- flush and stall both asserted on the same edge → out_valid = 0. wb_rd = 0 with wb_data = 5 → a subsequent read of x0 returns 0.
- Assert rst mid-stream with a valid instruction present → on the next edge every out_* = 0 and x5 reads 0.
